// File: rtl/io_seq_checker.sv
// io_seq_checker: snoops CPU output writes and checks that each of NCHAN
// consecutive ports (BASE_ADDR..BASE_ADDR+NCHAN-1) receives the sequence
// 0, STEP, 2*STEP, ... (mod 2^WIDTH). A run samples MAX_CYCLES edges, then
// raises done and reports pass, the error and output counts, and the first
// mismatch.
// Optional build macro: IO_SEQ_CHECKER_EARLY_STOP_EN ends the run on the
// first mismatch instead of running the full MAX_CYCLES.
module io_seq_checker #(
  parameter int WIDTH        = 16,
  parameter int NCHAN        = 4,
  parameter int BASE_ADDR    = 0,
  parameter int STEP         = 1,
  parameter int MAX_CYCLES   = 2000,
  parameter int EXPECT_COUNT = 25,
  localparam int CW          = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] bus,
  input  logic             DI,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      out_count,
  output logic [CW-1:0]    bad_chan,
  output logic [WIDTH-1:0] bad_got,
  output logic [WIDTH-1:0] bad_exp
);

  localparam int               CYC_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(MAX_CYCLES - 1);
  localparam logic [WIDTH-1:0] BASE     = WIDTH'(BASE_ADDR);
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] NCHAN_W  = WIDTH'(NCHAN);
  localparam logic [15:0]      EXPECT_W = 16'(EXPECT_COUNT);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CYC_W-1:0] cyc;
  logic [WIDTH-1:0] exp_q [NCHAN];

  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] offset;
  logic             hit;
  logic [CW-1:0]    chan;
  logic             mismatch;
  logic             first_bad;
  logic [15:0]      out_nxt;
  logic [15:0]      err_nxt;
  logic             enter_run;
  logic             finish;

  // Decode a hit on a checked port and the saturating counter updates it causes.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    diff      = {1'b0, addr} - {1'b0, BASE};
    offset    = diff[WIDTH-1:0];
    chan      = offset[CW-1:0];
    // A borrow out of the subtraction means addr is below BASE.
    hit       = (state == RUN) && DI && !diff[WIDTH] && (offset < NCHAN_W);
    mismatch  = hit && (bus != exp_q[chan]);
    first_bad = mismatch && (err_count == '0);
    out_nxt   = out_count;
    err_nxt   = err_count;
    if (hit && (out_count != '1)) out_nxt = out_count + 16'd1;
    if (mismatch && (err_count != '1)) err_nxt = err_count + 16'd1;
  end

  // Next-state logic: start launches a run from IDLE or DONE; RUN ends on its last sample.
  always_comb begin
    state_nxt = state;
    enter_run = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = RUN;
          enter_run = 1'b1;
        end
      end
      RUN: begin
        if (cyc == LAST_CYC) finish = 1'b1;
`ifdef IO_SEQ_CHECKER_EARLY_STOP_EN
        if (mismatch) finish = 1'b1;
`else
`endif
        if (finish) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Run bookkeeping: cycle counter, result counters, first-mismatch capture, verdict.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc       <= '0;
      err_count <= '0;
      out_count <= '0;
      bad_chan  <= '0;
      bad_got   <= '0;
      bad_exp   <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else if (enter_run) begin
      cyc       <= '0;
      err_count <= '0;
      out_count <= '0;
      bad_chan  <= '0;
      bad_got   <= '0;
      bad_exp   <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else if (state == RUN) begin
      cyc       <= cyc + CYC_W'(1);
      out_count <= out_nxt;
      err_count <= err_nxt;
      if (first_bad) begin
        bad_chan <= chan;
        bad_got  <= bus;
        bad_exp  <= exp_q[chan];
      end
      // The verdict uses the post-edge counts so a hit on the final edge is included.
      if (finish) begin
        done <= 1'b1;
        pass <= (err_nxt == '0) && (out_nxt == EXPECT_W);
      end
    end
  end

  // Per-channel expected values: cleared at run entry, advanced on every hit.
  always_ff @(posedge clk) begin
    // NOTE: this array is deliberately not reset; entering RUN clears it before
    // any hit can read it, so a reset term would only add load on the reset net.
    if (!reset) begin
      if (enter_run) begin
        for (int i = 0; i < NCHAN; i++) exp_q[i] <= '0;
      end else if (hit) begin
        exp_q[chan] <= exp_q[chan] + STEP_W;
      end
    end
  end

endmodule
